stdp_weight_update: RTL and testbench

Stochastic synaptic weight updater that sits directly downstream of the pulse comparator stage. It accepts one update request per handshake: a 7-bit probability and a direction (`inc`), the comparator's `prob`/`inc` outputs. It draws a Bernoulli sample by comparing an internal 7-bit maximal-length LFSR against that probability. On success it moves a saturating weight register by ±1 and keeps running counts of applied potentiations and depressions.

---
 rtl/stdp_weight_update_if.sv | 15 +
 rtl/stdp_weight_update.sv | 137 +++++++++++++
 tb/tb_stdp_weight_update.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/stdp_weight_update_if.sv
// Update-request handshake between the pulse comparator stage (master) and
// the stochastic weight updater (slave).
//   upd_valid : master -> slave, a request is present
//   upd_ready : slave -> master, the request is accepted this cycle
//   prob      : master -> slave, update probability 0..127 (meaning prob/127)
//   inc       : master -> slave, 1 = potentiate, 0 = depress
interface stdp_weight_update_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [6:0] prob;
  logic       inc;

  modport master (output upd_valid, output prob, output inc, input upd_ready);
  modport slave  (input upd_valid, input prob, input inc, output upd_ready);
endinterface

// File: rtl/stdp_weight_update.sv
// Stochastic synaptic weight updater. Each accepted request draws one
// Bernoulli sample by comparing a free-running 7-bit maximal-length LFSR with
// the request probability. On a hit, a saturating weight register moves by
// +/-1, and saturating counters record the applied steps.
//
// Ports:
//   clk, rst    : clock; synchronous active-high reset
//   upd         : request handshake (upd_valid/upd_ready/prob/inc), slave side
//   wt_load     : load wt_load_val into the weight (honoured in IDLE only)
//   wt_load_val : value to load
//   stat_clr    : clear n_inc and n_dec (wins over a coincident increment)
//   weight      : current weight
//   done        : one-cycle pulse when an update completes
//   changed     : valid with done, held until the next done; 1 if weight moved
//   n_inc/n_dec : saturating counts of applied +1 / -1 steps
module stdp_weight_update #(
  parameter int             W_WIDTH   = 3,
  parameter int             W_INIT    = 0,
  parameter logic [6:0]     LFSR_SEED = 7'h01,
  parameter int             CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  stdp_weight_update_if.slave  upd,
  input  logic                 wt_load,
  input  logic [W_WIDTH-1:0]   wt_load_val,
  input  logic                 stat_clr,
  output logic [W_WIDTH-1:0]   weight,
  output logic                 done,
  output logic                 changed,
  output logic [CNT_WIDTH-1:0] n_inc,
  output logic [CNT_WIDTH-1:0] n_dec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    APPLY  = 2'd2
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [6:0]           SEED_EFF = (LFSR_SEED == 7'h00) ? 7'h01 : LFSR_SEED;
  localparam logic [W_WIDTH-1:0]   W_RST    = W_WIDTH'(W_INIT);
  localparam logic [W_WIDTH-1:0]   W_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t     state_q, state_d;
  logic [6:0] lfsr;
  logic [6:0] prob_q;
  logic       inc_q;
  logic       hit_q;
  logic       do_inc, do_dec;

  // Free-running LFSR, x^7+x^6+1; independent of the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d       = state_q;
    upd.upd_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // A weight load takes priority and stalls acceptance for that cycle.
        upd.upd_ready = !wt_load;
        if (upd.upd_valid && !wt_load) state_d = SAMPLE;
      end
      SAMPLE:  state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Applied steps: a hit at a weight bound is dropped and not counted.
  assign do_inc = (state_q == APPLY) && hit_q &&  inc_q && (weight != W_MAX);
  assign do_dec = (state_q == APPLY) && hit_q && !inc_q && (weight != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      weight  <= W_RST;
      done    <= 1'b0;
      changed <= 1'b0;
      prob_q  <= '0;
      inc_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wt_load) begin
            weight <= wt_load_val;
          end else if (upd.upd_valid) begin
            prob_q <= upd.prob;
            inc_q  <= upd.inc;
          end
        end
        // LFSR >= 1 always, so prob 0 never hits and prob 127 always does.
        SAMPLE: hit_q <= (lfsr <= prob_q);
        APPLY: begin
          if (do_inc) weight <= weight + W_WIDTH'(1);
          if (do_dec) weight <= weight - W_WIDTH'(1);
          changed <= do_inc || do_dec;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Statistics counters: clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      n_inc <= '0;
      n_dec <= '0;
    end else begin
      if (do_inc && n_inc != CNT_MAX) n_inc <= n_inc + CNT_WIDTH'(1);
      if (do_dec && n_dec != CNT_MAX) n_dec <= n_dec + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_stdp_weight_update.sv
module tb_stdp_weight_update;

  logic       clk = 1'b0;
  logic       rst;
  logic       wt_load;
  logic [2:0] wt_load_val;
  logic       stat_clr;
  logic [2:0] weight;
  logic       done;
  logic       changed;
  logic [7:0] n_inc;
  logic [7:0] n_dec;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int d0;

  stdp_weight_update_if u_if ();

  stdp_weight_update #(
    .W_WIDTH  (3),
    .W_INIT   (3),
    .LFSR_SEED(7'h01),
    .CNT_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .upd        (u_if.slave),
    .wt_load    (wt_load),
    .wt_load_val(wt_load_val),
    .stat_clr   (stat_clr),
    .weight     (weight),
    .done       (done),
    .changed    (changed),
    .n_inc      (n_inc),
    .n_dec      (n_dec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and tally done pulses seen there.
  task automatic step();
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
  endtask

  // Leaves the bench at the falling edge of "cycle 0" after reset.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; u_if.upd_valid = 1'b0; wt_load = 1'b0; stat_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Handshake in the current cycle c; returns at c+3 with done visible.
  task automatic request(input logic [6:0] p, input logic i);
    u_if.upd_valid = 1'b1; u_if.prob = p; u_if.inc = i;
    step();
    u_if.upd_valid = 1'b0; u_if.prob = ~p; u_if.inc = ~i;
    step();
    step();
  endtask

  task automatic load(input logic [2:0] v);
    wt_load = 1'b1; wt_load_val = v;
    step();
    wt_load = 1'b0;
  endtask

  logic [6:0] lfsr_exp [7] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};

  initial begin
    rst = 1'b1; wt_load = 1'b0; wt_load_val = '0; stat_clr = 1'b0;
    u_if.upd_valid = 1'b0; u_if.prob = '0; u_if.inc = 1'b0;

    // Reset state
    do_reset();
    #1;
    check("rst_weight",  weight, 3);
    check("rst_done",    done, 0);
    check("rst_changed", changed, 0);
    check("rst_n_inc",   n_inc, 0);
    check("rst_n_dec",   n_dec, 0);
    check("rst_ready",   u_if.upd_ready, 1);
    check("lfsr_c0",     dut.lfsr, 7'h01);

    // LFSR sequence and period
    for (int k = 0; k < 7; k++) begin
      step();
      check("lfsr_seq", dut.lfsr, lfsr_exp[k]);
    end
    for (int k = 7; k < 127; k++) step();
    check("lfsr_period", dut.lfsr, 7'h01);

    // Threshold: LFSR is 02 in SAMPLE; prob 1 misses
    do_reset();
    request(7'd1, 1'b1);
    check("thr1_done",    done, 1);
    check("thr1_changed", changed, 0);
    check("thr1_weight",  weight, 3);

    // Threshold: prob 2 hits
    do_reset();
    request(7'd2, 1'b1);
    check("thr2_done",    done, 1);
    check("thr2_changed", changed, 1);
    check("thr2_weight",  weight, 4);
    check("thr2_n_inc",   n_inc, 1);
    check("thr2_ready",   u_if.upd_ready, 1);
    step();
    check("done_pulse",   done, 0);
    check("changed_held", changed, 1);

    // Counter clear
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("clr_n_inc", n_inc, 0);

    // Saturation at max
    load(3'd7);
    check("load7", weight, 7);
    request(7'd127, 1'b1);
    check("satmax_weight",  weight, 7);
    check("satmax_changed", changed, 0);
    check("satmax_n_inc",   n_inc, 0);

    // Saturation at zero
    load(3'd0);
    request(7'd127, 1'b0);
    check("satmin_weight", weight, 0);
    check("satmin_n_dec",  n_dec, 0);

    // prob 0 never hits
    d0 = done_cnt;
    for (int k = 0; k < 200; k++) request(7'd0, 1'b1);
    check("p0_weight", weight, 0);
    check("p0_dones",  done_cnt - d0, 200);
    check("p0_n_inc",  n_inc, 0);

    // prob 127 always hits
    for (int k = 0; k < 5; k++) request(7'd127, 1'b1);
    check("p127_weight", weight, 5);
    check("p127_n_inc",  n_inc, 5);

    // Load collides with a request: load wins, request not taken
    step();
    d0 = done_cnt;
    wt_load = 1'b1; wt_load_val = 3'd6;
    u_if.upd_valid = 1'b1; u_if.prob = 7'd127; u_if.inc = 1'b1;
    #1;
    check("coll_ready", u_if.upd_ready, 0);
    step();
    wt_load = 1'b0; u_if.upd_valid = 1'b0;
    check("coll_weight", weight, 6);
    step(); step(); step();
    check("coll_weight_after", weight, 6);
    check("coll_no_done", done_cnt - d0, 0);

    // stat_clr coincident with an applied increment
    u_if.upd_valid = 1'b1; u_if.prob = 7'd127; u_if.inc = 1'b1;
    step();
    u_if.upd_valid = 1'b0;
    step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("clrcoll_done",   done, 1);
    check("clrcoll_weight", weight, 7);
    check("clrcoll_n_inc",  n_inc, 0);

    // Reset during SAMPLE aborts the update
    step();
    d0 = done_cnt;
    u_if.upd_valid = 1'b1; u_if.prob = 7'd127; u_if.inc = 1'b0;
    step();
    u_if.upd_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_weight", weight, 3);
    check("midrst_done",   done, 0);
    step(); step(); step();
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_weight2", weight, 3);
    request(7'd127, 1'b1);
    check("post_rst_done",   done, 1);
    check("post_rst_weight", weight, 4);
    check("post_rst_n_inc",  n_inc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
